// File: rtl/ssio_ddr_out_if.sv
// Word-pair handshake between MAC TX logic and the DDR output serializer.
interface ssio_ddr_out_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] s_q1;
    logic [WIDTH-1:0] s_q2;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_q1, s_q2, s_valid, input s_ready);
    modport slave  (input s_q1, s_q2, s_valid, output s_ready);
endinterface

// File: rtl/ssio_ddr_out_ser.sv
// Source-synchronous DDR output: FIFO of {q1,q2} pairs, q1 on the high half, q2 on the low half,
// forwarded clock gated at posedge boundaries. Optional deskew training under SSIO_DDR_OUT_TRAIN_EN.

// One DDR pin: both halves captured at posedge, low half re-timed on negedge (ODDR same-edge form).
module ssio_ddr_out_cell #(
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d1,
    input  logic d2,
    output logic q
);
    logic d1_r, d2_r, d2_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= IDLE_BIT;
            d2_r <= IDLE_BIT;
        end else begin
            d1_r <= d1;
            d2_r <= d2;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) d2_n <= IDLE_BIT;
        else        d2_n <= d2_r;
    end

    assign q = clk ? d1_r : d2_n;
endmodule

module ssio_ddr_out_ser #(
    parameter string           TARGET           = "GENERIC",
    parameter int              WIDTH            = 4,
    parameter int              FIFO_DEPTH       = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = '0,
    parameter int              PREAMBLE_CYCLES  = 2,
    parameter int              IDLE_STOP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ssio_ddr_out_if.slave                 s,
`ifdef SSIO_DDR_OUT_TRAIN_EN
    input  logic                          train_req,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          gap,
    output logic                          output_clk,
    output logic [WIDTH-1:0]              output_d
);
    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_LVL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]      PRE_LAST    = 4'((PREAMBLE_CYCLES == 0) ? 0 : PREAMBLE_CYCLES - 1);
    localparam logic [7:0]      IDLE_STOP_T = 8'(IDLE_STOP_CYCLES);

    if (!(TARGET == "GENERIC" || TARGET == "SIM" || TARGET == "XILINX") ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("ssio_ddr_out_ser: unsupported TARGET or FIFO_DEPTH");
    end

    typedef enum logic [1:0] {ST_STOP, ST_WAKE, ST_RUN} state_t;

    state_t                              state, state_nxt;
    logic [FIFO_DEPTH-1:0][2*WIDTH-1:0]  mem;
    logic [AW-1:0]                       wr_ptr, rd_ptr;
    logic [AW:0]                         level, level_nxt;
    logic [3:0]                          pre_cnt, pre_cnt_nxt;
    logic [7:0]                          idle_cnt, idle_cnt_nxt;
    logic                                ready_r, push, pop, en, gap_nxt, wake_req;
    logic [WIDTH-1:0]                    sel_q1, sel_q2;

    assign push       = s.s_valid & ready_r;
    assign s.s_ready  = ready_r;
    assign fifo_level = level;

`ifdef SSIO_DDR_OUT_TRAIN_EN
    assign wake_req = (level != '0) | push | train_req;
`else
    assign wake_req = (level != '0) | push;
`endif

    always_comb begin
        state_nxt    = state;
        pre_cnt_nxt  = pre_cnt;
        idle_cnt_nxt = idle_cnt;
        pop          = 1'b0;
        en           = 1'b0;
        gap_nxt      = 1'b0;
        sel_q1       = IDLE_VALUE;
        sel_q2       = IDLE_VALUE;
        case (state)
            ST_STOP: begin
                pre_cnt_nxt  = '0;
                idle_cnt_nxt = '0;
                if (wake_req) state_nxt = (PREAMBLE_CYCLES == 0) ? ST_RUN : ST_WAKE;
            end
            ST_WAKE: begin
                en          = 1'b1;
                pre_cnt_nxt = pre_cnt + 4'd1;
                if (pre_cnt == PRE_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                en = 1'b1;
`ifdef SSIO_DDR_OUT_TRAIN_EN
                // Deskew pattern: pops, gap and idle timeout all paused while training.
                if (train_req) begin
                    sel_q1 = '1;
                    sel_q2 = '0;
                end else
`endif
                if (level != '0) begin
                    pop          = 1'b1;
                    sel_q1       = mem[rd_ptr][2*WIDTH-1:WIDTH];
                    sel_q2       = mem[rd_ptr][WIDTH-1:0];
                    idle_cnt_nxt = '0;
                end else begin
                    gap_nxt      = 1'b1;
                    idle_cnt_nxt = idle_cnt + 8'd1;
                    // This cycle still clocks IDLE out; the gate closes from the next edge.
                    if (IDLE_STOP_CYCLES != 0 && idle_cnt_nxt == IDLE_STOP_T) state_nxt = ST_STOP;
                end
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pre_cnt  <= '0;
            idle_cnt <= '0;
            ready_r  <= 1'b1;
            gap      <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            pre_cnt  <= pre_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            ready_r  <= (level_nxt != FULL_LVL);
            gap      <= gap_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s.s_q1, s.s_q2};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ssio_ddr_out_cell #(.IDLE_BIT(IDLE_VALUE[i])) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .d1    (sel_q1[i]),
            .d2    (sel_q2[i]),
            .q     (output_d[i])
        );
    end

    // Forwarded clock is just another DDR pin carrying en on the high half and 0 on the low half.
    ssio_ddr_out_cell #(.IDLE_BIT(1'b0)) u_clk_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .d1    (en),
        .d2    (1'b0),
        .q     (output_clk)
    );
endmodule
